// File: rtl/tmul_row_sequencer_pkg.sv
// Shared definitions for the tile multiplier: row geometry, row type and the
// row-sequencer state encoding.
package tmul_pkg;

    localparam int LANES   = 16;
    localparam int ELEM_W  = 16;
    localparam int ROW_W   = LANES * ELEM_W;
    localparam int MAX_DIM = 16;

    typedef logic [ROW_W-1:0] row_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LDC,
        S_MAC,
        S_WRC,
        S_DONE
    } seq_state_e;

endpackage

// File: rtl/tmul_row_sequencer.sv
// Row sequencer for the tile multiplier: walks C[m] += sum_k A[m][k]*B[k] one
// FMA_Row operation per cycle and writes each finished row back to C.
module tmul_row_sequencer
    import tmul_pkg::*;
#(
    parameter int LANES   = 16,
    parameter int ELEM_W  = 16,
    parameter int MAX_DIM = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [4:0]                cfg_m,
    input  logic [4:0]                cfg_k,
    output logic                      busy,
    output logic                      done,
    output logic [7:0]                a_raddr,
    input  logic [ELEM_W-1:0]         a_rdata,
    output logic [3:0]                b_raddr,
    input  logic [LANES*ELEM_W-1:0]   b_rdata,
    output logic [3:0]                c_raddr,
    input  logic [LANES*ELEM_W-1:0]   c_rdata,
    output logic                      c_we,
    output logic [3:0]                c_waddr,
    output logic [LANES*ELEM_W-1:0]   c_wdata,
    output logic [ELEM_W-1:0]         fma_a,
    output logic [LANES*ELEM_W-1:0]   fma_rowb,
    output logic [LANES*ELEM_W-1:0]   fma_rowc,
    input  logic [LANES*ELEM_W-1:0]   fma_product
);

    localparam int RW = LANES * ELEM_W;

    function automatic logic [4:0] sat_dim(input logic [4:0] d);
        return (d > 5'(MAX_DIM)) ? 5'(MAX_DIM) : d;
    endfunction

    seq_state_e      state;
    seq_state_e      nxt;
    logic [3:0]      m;
    logic [3:0]      k;
    logic [4:0]      m_eff;
    logic [4:0]      k_eff;
    logic [RW-1:0]   acc;
    logic            last_k;
    logic            last_m;
    logic            degenerate;
    logic            wr_next;
    logic            rd_en;
    logic            rd_c;
    logic [3:0]      rd_m;
    logic [3:0]      rd_k;
    logic [4:0]      kn;

    assign last_k     = ({1'b0, k} == (k_eff - 5'd1));
    assign last_m     = ({1'b0, m} == (m_eff - 5'd1));
    assign degenerate = (cfg_m == 5'd0) || (cfg_k == 5'd0);
    assign wr_next    = (state == S_MAC) && last_k;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    nxt = degenerate ? S_DONE : S_LDC;
                end
            end
            S_LDC:   nxt = S_MAC;
            S_MAC:   nxt = last_k ? S_WRC : S_MAC;
            S_WRC:   nxt = last_m ? S_DONE : S_LDC;
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // FMA operands are only live in MAC; the first term of a row adds onto C.
    always_comb begin
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
        fma_a    = '0;
        fma_rowb = '0;
        fma_rowc = '0;
        if (state == S_MAC) begin
            fma_a    = a_rdata;
            fma_rowb = b_rdata;
            fma_rowc = (k == 4'd0) ? c_rdata : acc;
        end
    end

    // Reads are issued one cycle ahead of the cycle that consumes their data.
    always_comb begin
        rd_en = 1'b0;
        rd_c  = 1'b0;
        rd_m  = m;
        rd_k  = 4'd0;
        kn    = (state == S_LDC) ? 5'd0 : ({1'b0, k} + 5'd1);
        if (nxt == S_LDC) begin
            rd_en = 1'b1;
            rd_c  = 1'b1;
            rd_m  = (state == S_WRC) ? (m + 4'd1) : 4'd0;
        end else if ((nxt == S_MAC) && ((kn + 5'd1) < k_eff)) begin
            rd_en = 1'b1;
            rd_k  = 4'(kn + 5'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m       <= '0;
            k       <= '0;
            m_eff   <= '0;
            k_eff   <= '0;
            acc     <= '0;
            a_raddr <= '0;
            b_raddr <= '0;
            c_raddr <= '0;
            c_we    <= 1'b0;
            c_waddr <= '0;
            c_wdata <= '0;
        end else begin
            a_raddr <= rd_en ? {rd_m, rd_k} : 8'd0;
            b_raddr <= rd_en ? rd_k : 4'd0;
            c_raddr <= rd_c ? rd_m : 4'd0;
            c_we    <= wr_next;
            c_waddr <= wr_next ? m : 4'd0;
            c_wdata <= wr_next ? fma_product : '0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        m_eff <= sat_dim(cfg_m);
                        k_eff <= sat_dim(cfg_k);
                        m     <= '0;
                        k     <= '0;
                    end
                end
                S_LDC: k <= '0;
                S_MAC: begin
                    acc <= fma_product;
                    if (!last_k) begin
                        k <= k + 4'd1;
                    end
                end
                S_WRC: begin
                    if (!last_m) begin
                        m <= m + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/tmul_row_sequencer.md
# tmul_row_sequencer

Drives the row-level FMA datapath of the FP16/BF16/INT8 tile multiplier: computes C[m] += Σk A[m][k]·B[k] for a configurable tile. Reads A, B and C from single-cycle-latency tile memories, presents one (scalar a, B row, C/accumulator row) triple per cycle to an external `FMA_Row`, captures its 256-bit `Row_product`, and writes each finished row back to C. It is the initiator side of the `FMA_Row` interface and sits between the tile register file and the FMA row array.

## Interface
Parameters:
- `LANES`, 16: elements per row.
- `ELEM_W`, 16: bits per element; row width is `LANES*ELEM_W` = 256.
- `MAX_DIM`, 16: maximum M and K.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: launch request; sampled only in IDLE.
- `cfg_m` in 5: tile rows M.
- `cfg_k` in 5: reduction depth K.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle completion pulse.
- `a_raddr` out 8: A element address `{m[3:0], k[3:0]}`.
- `a_rdata` in 16: A element, valid one cycle after its address.
- `b_raddr` out 4: B row index k.
- `b_rdata` in 256: B row, valid one cycle after its address.
- `c_raddr` out 4: C row index m.
- `c_rdata` in 256: C row, valid one cycle after its address.
- `c_we` out 1: C write strobe.
- `c_waddr` out 4: C row index for the write.
- `c_wdata` out 256: C row written back.
- `fma_a` out 16: scalar to `FMA_Row`.
- `fma_rowb` out 256: B row to `FMA_Row`.
- `fma_rowc` out 256: addend row to `FMA_Row`.
- `fma_product` in 256: combinational result from `FMA_Row`.

Row packing everywhere: lane j occupies bits [16j+15:16j].

## Operation
- States: IDLE, LDC, MAC, WRC, DONE.
- **IDLE:** `busy`=0. On `start`, latch the effective M and K, clear m and k.
  - Each of `cfg_m` and `cfg_k` saturates to 16 if it is greater than 16.
  - If either is 0, go directly to DONE with no memory access.
  - Otherwise go to LDC.
- **LDC** (1 cycle): drive `c_raddr`=m, `a_raddr`={m,0}, `b_raddr`=0; go to MAC.
- **MAC** (K cycles, k = 0..K-1):
  - Drive `fma_a`=`a_rdata` and `fma_rowb`=`b_rdata`.
  - Drive `fma_rowc`=`c_rdata` when k==0, else the accumulator register.
  - Capture `fma_product` into the accumulator at the clock edge.
  - While k<K-1, issue the reads for k+1: `a_raddr`={m,k+1}, `b_raddr`=k+1.
  - After the cycle with k==K-1, go to WRC.
- **WRC** (1 cycle): `c_we`=1, `c_waddr`=m, `c_wdata`=accumulator. Then, if m==M-1, go to DONE; else increment m and go to LDC.
- **DONE** (1 cycle): `done`=1; return to IDLE.
- `start` is ignored outside IDLE; config changes during busy have no effect.
- The sequencer does no arithmetic. Number format (FP16/BF16/INT8) is the concern of `FMA_Row` alone; rows pass through bit-exact.
- Whenever the `fma_*` outputs are not being consumed (every state other than MAC), they are driven to 0.

## Timing
- Reset (any state, including mid-tile) → IDLE next edge. All outputs are 0 and the accumulator is cleared. No C write is issued for the interrupted row; rows already written stay written.
- Read addresses are registered outputs, presented in the cycle before their data is consumed.
- Write strobe and FMA operands:
  - `c_we` and `c_wdata` are registered outputs.
  - The `fma_*` outputs are combinational from the memory data and the accumulator; the combinational path is memory → FMA → accumulator.
- Throughput: one FMA per cycle within a row. Each row costs K+2 cycles (LDC, K×MAC, WRC).
- Latency:
  - For M,K ≥ 1, `done` asserts M·(K+2)+1 cycles after the `start` cycle.
  - Degenerate config (M or K equal to 0): `done` asserts 1 cycle after `start`.
- `busy` rises the cycle after `start` is accepted and falls with the cycle after `done`.
- `start` held high through DONE re-launches on the next IDLE cycle.

## Structure
- Shared package `tmul_pkg` holds:
  - Constants `LANES`, `ELEM_W`, `ROW_W`=256, `MAX_DIM`.
  - Typedef `row_t` (logic [ROW_W-1:0]).
  - The state enum `seq_state_e`.
- The same package is used by `FMA_Row` wrappers and tile memories.
- No sub-module. The sequencer is a single FSM plus m/k counters and the accumulator. `FMA_Row` is instantiated beside it in the tile top, not inside it.

## Test plan
The bench models the memories with 1-cycle read latency. It stubs `FMA_Row` as lane-wise integer a·b+c mod 2^16 to check sequencing, plus one run with the real `FMA_Row`.
- **Single element:** M=1, K=1, A[0][0]=3, B[0]=all 2, C[0]=all 1 → one write, C[0]=all 7. `done` at start+4.
- **Full tile:** M=16, K=16 with A=1, B[k] lane j = j, C=0 → every C row has lane j = 16·j mod 2^16. 16 writes; `done` at start+289.
- **Degenerate config:** `cfg_k`=0 → no reads or writes, `done` at start+1. `cfg_m`=20 → behaves as M=16.
- **Start handling:** `start` pulsed mid-run is ignored and results are unchanged. `start` held high produces back-to-back runs.
- **Reset mid-operation:** reset asserted during MAC of row 2 → next-cycle outputs are all 0 and `busy`=0. Rows 0–1 are written; row 2 is not.
- **Real FMA:** a=16'h3C00 (FP16 1.0), B lane0=16'h3C00, C lane0=16'h3C00, M=K=1 → C lane0=16'h4000.
